// File: rtl/framer_pkg.sv
// Shared defaults, buffer depth derivation and FSM state encoding for the STFT framer.
package framer_pkg;

  localparam int DATA_W_DEF    = 20;
  localparam int FRAME_LEN_DEF = 1024;
  localparam int HOP_DEF       = 256;

  function automatic int depth_of(input int frame_len);
    return 2 * frame_len;
  endfunction

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/framer_ram.sv
// Simple dual-port sample store: one write port, one registered read port (1-cycle latency).
// Contents are never reset; the pointer logic in the parent decides what is valid.
module framer_ram #(
  parameter int DATA_W = 20,
  parameter int AW     = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stft_framer.sv
// Slices a sample stream into overlapping frames of FRAME_LEN advancing by HOP; out lags
// the EMIT read by 1 cycle; input stalls (in_ready low) only when the 2*FRAME_LEN buffer is full.
module stft_framer
  import framer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int HOP       = HOP_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_W-1:0]     in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_W-1:0]     out,
  output logic                         out_valid,
  output logic [$clog2(FRAME_LEN)-1:0] out_num,
  output logic [15:0]                  frame_cnt
);

  localparam int DEPTH = depth_of(FRAME_LEN);
  localparam int AW    = $clog2(DEPTH);
  localparam int NW    = $clog2(FRAME_LEN);
  localparam int PW    = AW + 1;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] FL_P    = PW'(FRAME_LEN);
  localparam logic [PW-1:0] HOP_P   = PW'(HOP);
  localparam logic [PW-1:0] NEXT_P  = PW'(FRAME_LEN + HOP);
  localparam logic [NW-1:0] LAST_K  = NW'(FRAME_LEN - 1);

  state_t                   state;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            base_ptr;
  logic [PW-1:0]            occ;
  logic [NW-1:0]            k;
  logic                     wr_en;
  logic                     rd_en;
  logic [AW-1:0]            rd_addr;
  logic signed [DATA_W-1:0] rd_data;

  // Pointers carry one extra bit so full (DEPTH) and empty (0) are distinguishable.
  assign occ      = wr_ptr - base_ptr;
  assign in_ready = occ < DEPTH_P;
  assign wr_en    = in_valid && in_ready;
  assign rd_en    = (state == ST_EMIT);
  assign rd_addr  = base_ptr[AW-1:0] + AW'(k);

  // The read register holds stale data between frames; blank it so idle output is zero.
  assign out = out_valid ? rd_data : '0;

  framer_ram #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_WAIT;
      wr_ptr    <= '0;
      base_ptr  <= '0;
      k         <= '0;
      frame_cnt <= '0;
      out_valid <= 1'b0;
      out_num   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      out_valid <= rd_en;
      out_num   <= rd_en ? k : '0;
      case (state)
        ST_WAIT: begin
          if (occ >= FL_P) state <= ST_EMIT;
        end
        ST_EMIT: begin
          // k wraps back to 0 on the last read since FRAME_LEN is a power of two.
          k <= k + NW'(1);
          if (k == LAST_K) state <= ST_GAP;
        end
        ST_GAP: begin
          base_ptr  <= base_ptr + HOP_P;
          frame_cnt <= frame_cnt + 16'd1;
          // Occupancy after the hop still covers a whole frame iff occ >= FRAME_LEN + HOP now.
          state     <= (occ >= NEXT_P) ? ST_EMIT : ST_WAIT;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_stft_framer.sv
// Bench for stft_framer: frame-slicing scoreboard over the accepted-sample history,
// directed scenarios with literal expectations, and a HOP = FRAME_LEN build.
module tb_stft_framer;

  localparam int DW    = 20;
  localparam int FL    = 1024;
  localparam int HOPV  = 256;
  localparam int DEPTH = 2 * FL;
  localparam int NW    = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] din = '0;
  logic                 vld = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] out;
  logic                 out_valid;
  logic [NW-1:0]        out_num;
  logic [15:0]          frame_cnt;

  logic                 rst2 = 1'b1;
  logic signed [DW-1:0] din2 = '0;
  logic                 vld2 = 1'b0;
  logic                 in_ready2;
  logic signed [DW-1:0] out2;
  logic                 out_valid2;
  logic [NW-1:0]        out_num2;
  logic [15:0]          frame_cnt2;

  always #5 clk = ~clk;

  stft_framer #(.DATA_W(DW), .FRAME_LEN(FL), .HOP(HOPV)) dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(vld), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_num(out_num), .frame_cnt(frame_cnt));

  stft_framer #(.DATA_W(DW), .FRAME_LEN(FL), .HOP(FL)) dut2 (
    .clk(clk), .rst(rst2), .in(din2), .in_valid(vld2), .in_ready(in_ready2),
    .out(out2), .out_valid(out_valid2), .out_num(out_num2), .frame_cnt(frame_cnt2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame n is accepted samples n*HOP .. n*HOP+FL-1.
  logic signed [DW-1:0] hist[$];
  int  n_acc = 0, exp_frame = 0, exp_idx = 0, pos;
  bit  exp_rdy, prev_valid, rst_prev = 0, chk_en = 0, saw_valid, saw_full;
  int  first_v[16], last_v[16];

  initial forever begin
    @(negedge clk);
    if (rst_prev) begin
      hist.delete();
      n_acc = 0; exp_frame = 0; exp_idx = 0; prev_valid = 0; chk_en = 1;
      saw_valid = 0; saw_full = 0;
      for (int i = 0; i < 16; i++) begin first_v[i] = -1; last_v[i] = -1; end
    end
    exp_rdy = (n_acc - exp_frame * HOPV) < DEPTH;
    if (chk_en) begin
      check("in_ready", in_ready, exp_rdy);
      check("frame_cnt", frame_cnt, exp_frame % 65536);
      if (out_valid) begin
        if (exp_idx == 0 && prev_valid) check("gap_between_frames", 0, 1);
        pos = exp_frame * HOPV + exp_idx;
        if (pos >= hist.size()) check("out_beyond_accepted", pos, hist.size() - 1);
        else check("out_sample", out, hist[pos]);
        check("out_num", out_num, exp_idx);
        if (exp_frame < 16 && exp_idx == 0) first_v[exp_frame] = int'(out);
        if (exp_frame < 16 && exp_idx == FL - 1) last_v[exp_frame] = int'(out);
        exp_idx++;
        if (exp_idx == FL) begin exp_idx = 0; exp_frame++; end
      end else begin
        if (exp_idx != 0) check("valid_dropped_mid_frame", exp_idx, 0);
        check("idle_out", out, 0);
        check("idle_out_num", out_num, 0);
      end
      prev_valid = out_valid;
      if (out_valid) saw_valid = 1;
      if (!in_ready) saw_full = 1;
      if (!rst && vld && exp_rdy) begin hist.push_back(din); n_acc++; end
    end
    rst_prev = rst;
  end

  // HOP = FRAME_LEN model: frame f holds ramp values f*FL .. f*FL+FL-1.
  bit e_on = 0;
  int f2 = 0, i2 = 0, e_first[4], e_last[4];

  initial forever begin
    @(negedge clk);
    if (e_on && out_valid2) begin
      check("e_out", out2, f2 * FL + i2);
      check("e_num", out_num2, i2);
      if (f2 < 4 && i2 == 0) e_first[f2] = int'(out2);
      if (f2 < 4 && i2 == FL - 1) e_last[f2] = int'(out2);
      i2++;
      if (i2 == FL) begin i2 = 0; f2++; end
    end
  end

  int v;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Ramp producer honouring in_ready; stops on frame count or on a given out_num of a frame.
  task automatic drive(input int period, input int max_cyc, input int stop_frame,
                       input int stop_num, output bit ok);
    bit acc, stop;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      vld = (i % period) == 0;
      din = DW'(v);
      @(negedge clk); #1;
      acc  = vld && in_ready;
      stop = (stop_num < 0) ? (exp_frame >= stop_frame)
                            : (out_valid && exp_frame == stop_frame && int'(out_num) == stop_num);
      tick();
      if (acc) v++;
      if (stop) begin ok = 1; break; end
    end
    vld = 1'b0;
  endtask

  bit ok;
  int t, run;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Continuous ramp: reset state, overlap contents, back-pressure over frames 0..7.
    do_reset();
    @(negedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_out_num", out_num, 0);
    tick();
    v = 0;
    drive(1, 12000, 8, -1, ok);
    check("A_done", ok, 1);
    check("A_saw_full", saw_full, 1);
    check("A_f0_first", first_v[0], 0);
    check("A_f0_last", last_v[0], 1023);
    check("A_f1_first", first_v[1], 256);
    check("A_f1_last", last_v[1], 1279);
    check("A_f2_first", first_v[2], 512);
    check("A_f2_last", last_v[2], 1535);

    // Sparse input, one sample every fourth cycle.
    do_reset();
    v = 0;
    drive(4, 12000, 3, -1, ok);
    check("C_done", ok, 1);
    check("C_f0_first", first_v[0], 0);
    check("C_f1_first", first_v[1], 256);
    check("C_f1_last", last_v[1], 1279);
    check("C_f2_last", last_v[2], 1535);

    // One short of a frame, then the sample that completes it.
    do_reset();
    v = 0;
    drive(1, 1023, 99, -1, ok);
    repeat (100) tick();
    check("B_no_valid_1023", saw_valid, 0);
    din = DW'(v); vld = 1'b1;
    tick();
    vld = 1'b0; v++;
    t = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      t++;
      if (out_valid) break;
    end
    check("B_rise_within_3", (out_valid && t <= 3) ? 1 : 0, 1);
    run = out_valid ? 1 : 0;
    for (int i = 0; i < 2000 && out_valid; i++) begin
      @(negedge clk); #1;
      if (out_valid) run++;
    end
    check("B_run_len", run, FL);
    check("B_frame_cnt", frame_cnt, 1);
    tick();

    // Reset in the middle of frame 1, then restart the ramp from 100.
    do_reset();
    v = 0;
    drive(1, 4000, 1, 499, ok);
    check("D_reached_500", ok, 1);
    rst = 1'b1;
    tick();
    check("D_valid_after_rst", out_valid, 0);
    check("D_cnt_after_rst", frame_cnt, 0);
    rst = 1'b0;
    v = 100;
    drive(1, 4000, 1, -1, ok);
    check("D_done", ok, 1);
    check("D_f0_first", first_v[0], 100);
    check("D_f0_last", last_v[0], 1123);

    // Non-overlapping build.
    rst2 = 1'b1; tick(); tick(); rst2 = 1'b0;
    e_on = 1;
    v = 0; ok = 0;
    for (int i = 0; i < 6000; i++) begin
      bit acc;
      din2 = DW'(v); vld2 = 1'b1;
      @(negedge clk); #1;
      acc = in_ready2;
      tick();
      if (acc) v++;
      if (f2 >= 2) begin ok = 1; break; end
    end
    vld2 = 1'b0;
    check("E_done", ok, 1);
    check("E_f0_first", e_first[0], 0);
    check("E_f0_last", e_last[0], 1023);
    check("E_f1_first", e_first[1], 1024);
    check("E_f1_last", e_last[1], 2047);
    check("E_frame_cnt", frame_cnt2, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
